// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding and default timer widths for the bus arbiter
package bus_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWNED   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;
  localparam int GRANT_WAIT_LEN_DEF = 4;
  localparam int HOLD_LEN_DEF = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin requester select, searching from last+1 by rotate and priority-encode
module rr_pick #(
  parameter int N = 3,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic            valid,
  output logic [ID_W-1:0] idx
);
  logic [ID_W:0] nxt;
  logic [ID_W:0] sh;
  logic [N-1:0]  rot;
  assign nxt = {1'b0, last} + (ID_W+1)'(1);
  assign sh = (nxt >= (ID_W+1)'(N)) ? '0 : nxt;
  assign rot = N'({req, req} >> sh);
  always_comb begin
    valid = |rot;
    idx = '0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) idx = ID_W'((j + int'(sh)) % N);
  end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter with grant-uptake and ownership timeouts
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ID_W = 2,
  parameter int GRANT_WAIT_LEN = GRANT_WAIT_LEN_DEF,
  parameter int HOLD_LEN = HOLD_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] b_request,
  input  logic                   bus_util,
  output logic [NUM_MASTERS-1:0] b_grant,
  output logic                   arbiter_cmd,
  output logic [ID_W-1:0]        owner,
  output logic [1:0]             arb_state,
  output logic [7:0]             abort_cnt
);
  // timeouts fire on the edge where the timer would reach all-ones
  localparam logic [GRANT_WAIT_LEN-1:0] G_PRE = GRANT_WAIT_LEN'(2 ** GRANT_WAIT_LEN - 2);
  localparam logic [HOLD_LEN-1:0] H_PRE = HOLD_LEN'(2 ** HOLD_LEN - 2);
  arb_state_e state, state_n;
  logic [ID_W-1:0] last, pick_idx;
  logic pick_valid;
  logic [GRANT_WAIT_LEN-1:0] gtimer;
  logic [HOLD_LEN-1:0] htimer;
  logic i_go, g_take, g_drop, g_to, o_rel, o_to, revoke;
  rr_pick #(.N(NUM_MASTERS), .ID_W(ID_W)) u_pick (
    .req(b_request),
    .last(last),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  assign i_go = state == IDLE && bus_util && pick_valid;
  assign g_take = state == GRANT && !bus_util;
  assign g_drop = state == GRANT && bus_util && !b_request[owner];
  assign g_to = state == GRANT && bus_util && b_request[owner] && gtimer == G_PRE;
  assign o_rel = state == OWNED && bus_util;
  assign o_to = state == OWNED && !bus_util && htimer == H_PRE;
  assign revoke = g_drop || g_to || o_rel || o_to;
  assign arb_state = state;
  always_comb begin
    state_n = i_go ? GRANT : g_take ? OWNED : revoke ? RELEASE : state == RELEASE ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_grant <= '0;
      owner <= '0;
      last <= ID_W'(NUM_MASTERS - 1);
      gtimer <= '0;
      htimer <= '0;
      abort_cnt <= '0;
      arbiter_cmd <= 1'b0;
    end else begin
      arbiter_cmd <= o_to;
      if (i_go) begin
        b_grant <= NUM_MASTERS'(1) << pick_idx;
        owner <= pick_idx;
        gtimer <= '0;
      end else if (state == GRANT) gtimer <= gtimer + GRANT_WAIT_LEN'(1);
      if (g_take) htimer <= '0;
      else if (state == OWNED) htimer <= htimer + HOLD_LEN'(1);
      if (revoke) begin
        b_grant <= '0;
        last <= owner;
      end
      if ((g_to || o_to) && abort_cnt != 8'hff) abort_cnt <= abort_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed-vector bench for bus_arbiter_rr
module tb_bus_arbiter_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] b_request = '0;
  logic bus_util = 1'b1;
  logic [2:0] b_grant;
  logic arbiter_cmd;
  logic [1:0] owner;
  logic [1:0] arb_state;
  logic [7:0] abort_cnt;
  int n_vec = 0;
  int n_bad = 0;
  int pulses;
  int seq [5] = '{0, 1, 2, 0, 1};

  bus_arbiter_rr dut (
    .clk(clk),
    .rst(rst),
    .b_request(b_request),
    .bus_util(bus_util),
    .b_grant(b_grant),
    .arbiter_cmd(arbiter_cmd),
    .owner(owner),
    .arb_state(arb_state),
    .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_grant", 32'(b_grant), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_state", 32'(arb_state), 0);
    chk("rst_cmd", 32'(arbiter_cmd), 0);
    chk("rst_abort", 32'(abort_cnt), 0);

    b_request = 3'b010;
    tick();
    chk("single_grant", 32'(b_grant), 32'b010);
    chk("single_state_g", 32'(arb_state), 1);
    bus_util = 1'b0;
    tick(10);
    chk("single_owned", 32'(arb_state), 2);
    chk("single_hold_grant", 32'(b_grant), 32'b010);
    bus_util = 1'b1;
    tick();
    chk("single_rel_grant", 32'(b_grant), 0);
    chk("single_rel_state", 32'(arb_state), 3);
    chk("single_owner", 32'(owner), 1);
    b_request = 3'b000;
    tick();
    chk("single_idle", 32'(arb_state), 0);
    chk("single_abort", 32'(abort_cnt), 0);

    do_reset();
    b_request = 3'b111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_grant", 32'(b_grant), 32'(1 << seq[k]));
      chk("rr_owner", 32'(owner), 32'(seq[k]));
      bus_util = 1'b0;
      tick(3);
      bus_util = 1'b1;
      tick();
      chk("rr_gap", 32'(b_grant), 0);
      tick();
      chk("rr_idle", 32'(arb_state), 0);
    end

    do_reset();
    b_request = 3'b101;
    pulses = 0;
    tick();
    chk("gto_grant", 32'(b_grant), 32'b001);
    for (int k = 0; k < 14; k++) begin
      tick();
      pulses += int'(arbiter_cmd);
      chk("gto_held", 32'(b_grant), 32'b001);
    end
    tick();
    pulses += int'(arbiter_cmd);
    chk("gto_revoked", 32'(b_grant), 0);
    chk("gto_abort", 32'(abort_cnt), 1);
    tick();
    pulses += int'(arbiter_cmd);
    tick();
    chk("gto_next_m2", 32'(b_grant), 32'b100);
    chk("gto_no_cmd", 32'(pulses), 0);

    do_reset();
    b_request = 3'b001;
    pulses = 0;
    tick();
    chk("hto_grant", 32'(b_grant), 32'b001);
    bus_util = 1'b0;
    tick();
    for (int k = 0; k < 254; k++) begin
      tick();
      pulses += int'(arbiter_cmd);
    end
    chk("hto_held", 32'(b_grant), 32'b001);
    chk("hto_owned", 32'(arb_state), 2);
    tick();
    pulses += int'(arbiter_cmd);
    chk("hto_revoked", 32'(b_grant), 0);
    chk("hto_cmd", 32'(arbiter_cmd), 1);
    chk("hto_abort", 32'(abort_cnt), 1);
    for (int k = 0; k < 44; k++) begin
      tick();
      pulses += int'(arbiter_cmd);
    end
    chk("hto_no_regrant", 32'(b_grant), 0);
    chk("hto_one_pulse", 32'(pulses), 1);

    bus_util = 1'b1;
    tick();
    chk("rmid_grant", 32'(b_grant), 32'b001);
    bus_util = 1'b0;
    tick();
    chk("rmid_owned", 32'(arb_state), 2);
    rst = 1'b1;
    #1;
    chk("rmid_grant0", 32'(b_grant), 0);
    chk("rmid_state0", 32'(arb_state), 0);
    chk("rmid_abort0", 32'(abort_cnt), 0);
    chk("rmid_cmd0", 32'(arbiter_cmd), 0);
    tick();
    rst = 1'b0;
    b_request = 3'b110;
    bus_util = 1'b1;
    tick();
    chk("rmid_first_m1", 32'(b_grant), 32'b010);

    do_reset();
    b_request = 3'b001;
    tick();
    chk("sim_grant", 32'(b_grant), 32'b001);
    b_request = 3'b000;
    bus_util = 1'b0;
    tick();
    chk("sim_owned", 32'(arb_state), 2);
    tick(254);
    chk("sim_still_owned", 32'(arb_state), 2);
    bus_util = 1'b1;
    tick();
    chk("sim_release", 32'(arb_state), 3);
    chk("sim_no_cmd", 32'(arbiter_cmd), 0);
    chk("sim_abort", 32'(abort_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
